// File: rtl/quant_coeff_pkg.sv
// Shared definitions for the quantiser coefficient loader: FSM states,
// command word bit positions and status word bit positions.
package quant_coeff_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RD_WAIT = 2'd2,
        CMP     = 2'd3
    } state_t;

    // Command word (addr_reg) bit positions
    localparam int CMD_COMMIT = 31;
    localparam int CMD_FILL   = 30;
    localparam int CMD_CLR    = 29;

    // Status word bit positions; bits [15:0] carry the write count
    localparam int ST_BUSY = 16;
    localparam int ST_VERR = 17;
    localparam int ST_DROP = 18;

endpackage

// File: rtl/quant_cmd_detect.sv
// Turns the software commit toggle into a one-cycle commit pulse.
// The first clock after reset only captures the toggle level (arming), so a
// toggle bit already set at reset release never fires. Every toggle is seen
// exactly once because the history register follows the input every cycle.
module quant_cmd_detect (
    input  logic user_clk,
    input  logic user_rst,
    input  logic toggle,
    input  logic clr,
    output logic commit,
    output logic commit_wr,
    output logic commit_clr
);

    logic tog_q;
    logic armed;

    // Toggle history and arming flag
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            tog_q <= 1'b0;
            armed <= 1'b0;
        end else begin
            tog_q <= toggle;
            armed <= 1'b1;
        end
    end

    // Edge detection and clear/write decode
    always_comb begin
        commit     = armed & (toggle ^ tog_q);
        commit_clr = commit & clr;
        commit_wr  = commit & ~clr;
    end

endmodule

// File: rtl/quant_coeff_loader.sv
// Quantiser coefficient loader: converts software commits into write cycles
// on the coefficient RAM port (single word or fill to the top of the RAM) and
// reports progress on a status word.
// Optional build macro: QUANT_COEFF_LOADER_VERIFY_EN adds a read-back compare
// after every write (RD_WAIT for RAM_RD_LAT cycles, then CMP).
//
// RAM port handshake: the RAM is always ready; a write happens on every clock
// where coef_we is high, using coef_addr/coef_din of that cycle. coef_addr and
// coef_din hold their last values whenever coef_we is low.
module quant_coeff_loader
    import quant_coeff_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int COEF_W     = 18,
    parameter int RAM_RD_LAT = 2
) (
    input  logic              user_clk,
    input  logic              user_rst,
    input  logic [31:0]       addr_reg,
    input  logic [31:0]       data_reg,
    output logic              coef_we,
    output logic [ADDR_W-1:0] coef_addr,
    output logic [COEF_W-1:0] coef_din,
    input  logic [COEF_W-1:0] coef_dout,
    output logic              busy,
    output logic [31:0]       status
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_t            state;
    state_t            state_nxt;
    logic              commit;
    logic              commit_wr;
    logic              commit_clr;
    logic              fill_q;
    logic [ADDR_W-1:0] addr_q;
    logic [COEF_W-1:0] data_q;
    logic [15:0]       wr_count;
    logic              drop;
    logic              verr;
    logic              last_word;
    logic              addr_step;
    logic              unused_ok;

    quant_cmd_detect u_cmd_detect (
        .user_clk   (user_clk),
        .user_rst   (user_rst),
        .toggle     (addr_reg[CMD_COMMIT]),
        .clr        (addr_reg[CMD_CLR]),
        .commit     (commit),
        .commit_wr  (commit_wr),
        .commit_clr (commit_clr)
    );

    // A single write is always its own last word; a fill stops at the top
    assign last_word = ~fill_q | (addr_q == ADDR_MAX);

`ifdef QUANT_COEFF_LOADER_VERIFY_EN
    localparam logic [7:0] RD_LAST = 8'(RAM_RD_LAT - 1);

    logic [7:0] rd_cnt;

    // Address advances once the compare of the current word is done
    assign addr_step = (state == CMP) & ~last_word;

    // Read latency counter for RD_WAIT
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst)
            rd_cnt <= '0;
        else if (state == RD_WAIT)
            rd_cnt <= rd_cnt + 8'd1;
        else
            rd_cnt <= '0;
    end

    // Sticky verify error: set on read-back mismatch, cleared by a clear commit
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst)
            verr <= 1'b0;
        else if (state == CMP && coef_dout != data_q)
            verr <= 1'b1;
        else if (state == IDLE && commit_clr)
            verr <= 1'b0;
    end

    assign unused_ok = ^{data_reg[31:COEF_W], addr_reg[28:ADDR_W]};
`else
    // Address advances right after each write
    assign addr_step = (state == WRITE) & ~last_word;
    assign verr      = 1'b0;
    assign unused_ok = ^{coef_dout, data_reg[31:COEF_W], addr_reg[28:ADDR_W],
                         RAM_RD_LAT[0]};
`endif

    // FSM state register
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (commit_wr)
                    state_nxt = WRITE;
            end
            WRITE: begin
`ifdef QUANT_COEFF_LOADER_VERIFY_EN
                state_nxt = RD_WAIT;
`else
                if (last_word)
                    state_nxt = IDLE;
`endif
            end
`ifdef QUANT_COEFF_LOADER_VERIFY_EN
            RD_WAIT: begin
                if (rd_cnt == RD_LAST)
                    state_nxt = CMP;
            end
            CMP: begin
                state_nxt = last_word ? IDLE : WRITE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: write strobe and busy flag
    always_comb begin
        coef_we = (state == WRITE);
        busy    = (state != IDLE);
    end

    // Command latch and fill address counter
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            addr_q <= '0;
            data_q <= '0;
            fill_q <= 1'b0;
        end else if (state == IDLE && commit_wr) begin
            addr_q <= addr_reg[ADDR_W-1:0];
            data_q <= data_reg[COEF_W-1:0];
            fill_q <= addr_reg[CMD_FILL];
        end else if (addr_step) begin
            addr_q <= addr_q + 1'b1;
        end
    end

    assign coef_addr = addr_q;
    assign coef_din  = data_q;

    // Write counter, wraps modulo 2^16
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst)
            wr_count <= '0;
        else if (coef_we)
            wr_count <= wr_count + 16'd1;
    end

    // Sticky dropped-commit flag: any commit while busy is dropped
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst)
            drop <= 1'b0;
        else if (commit && state != IDLE)
            drop <= 1'b1;
        else if (state == IDLE && commit_clr)
            drop <= 1'b0;
    end

    // Status word assembly
    always_comb begin
        status          = '0;
        status[15:0]    = wr_count;
        status[ST_BUSY] = busy;
        status[ST_VERR] = verr;
        status[ST_DROP] = drop;
    end

endmodule

// File: tb/tb_quant_coeff_loader.sv
// Directed bench for quant_coeff_loader: stimulus pushes the expected RAM
// writes into a queue, a negedge monitor pops and compares every coef_we
// cycle, and the main sequence checks status/busy at hand-computed points.
module tb_quant_coeff_loader;

`ifdef QUANT_COEFF_LOADER_VERIFY_EN
    localparam bit VERIFY   = 1'b1;
    localparam int WORD_CYC = 4;
`else
    localparam bit VERIFY   = 1'b0;
    localparam int WORD_CYC = 1;
`endif

    logic        user_clk;
    logic        user_rst;
    logic [31:0] addr_reg;
    logic [31:0] data_reg;
    logic        coef_we;
    logic [9:0]  coef_addr;
    logic [17:0] coef_din;
    logic [17:0] coef_dout;
    logic        busy;
    logic [31:0] status;

    logic [27:0] exp_q[$];
    int vectors;
    int miscompares;
    int wr_seen;

    quant_coeff_loader #(.ADDR_W(10), .COEF_W(18), .RAM_RD_LAT(2)) dut (
        .user_clk  (user_clk),
        .user_rst  (user_rst),
        .addr_reg  (addr_reg),
        .data_reg  (data_reg),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_din  (coef_din),
        .coef_dout (coef_dout),
        .busy      (busy),
        .status    (status)
    );

    // clock / reset block
    initial begin
        user_clk = 1'b0;
        forever #5 user_clk = ~user_clk;
    end

    // RAM model, read latency 2, address 3 reads back corrupted
    logic [17:0] mem [0:1023];
    logic [17:0] rd0;
    always @(posedge user_clk) begin
        if (coef_we)
            mem[coef_addr] <= coef_din;
        rd0       <= (coef_addr == 10'd3) ? (mem[coef_addr] ^ 18'h1) : mem[coef_addr];
        coef_dout <= rd0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge user_clk) begin
        if (!user_rst && coef_we) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: addr 0x%0h din 0x%0h, none expected", coef_addr, coef_din);
            end else begin
                logic [27:0] e;
                e = exp_q.pop_front();
                check("write_addr_data", {4'h0, coef_addr, coef_din}, {4'h0, e});
            end
        end
    end

    task automatic commit(input logic [9:0] a, input logic [17:0] d, input bit fill, input bit clr);
        @(negedge user_clk);
        data_reg = {14'h0, d};
        addr_reg = {~addr_reg[31], fill, clr, 19'h0, a};
    endtask

    task automatic expect_write(input logic [9:0] a, input logic [17:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge user_clk);
        while (busy && n < budget) begin
            @(negedge user_clk);
            n++;
        end
        check("idle_timeout", {31'h0, busy}, 32'h0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        wr_seen     = 0;
        user_rst    = 1'b1;
        addr_reg    = 32'h8000_0000;
        data_reg    = 32'h0;

        // reset state, toggle bit already high at release
        repeat (3) @(negedge user_clk);
        check("reset_status", status, 32'h0);
        check("reset_we", {31'h0, coef_we}, 32'h0);
        user_rst = 1'b0;
        repeat (20) @(negedge user_clk);
        check("release_no_write", wr_seen, 0);
        check("release_status", status, 32'h0);

        // single write
        expect_write(10'd5, 18'h1ABCD);
        commit(10'd5, 18'h1ABCD, 1'b0, 1'b0);
        @(negedge user_clk);
        check("single_we", {31'h0, coef_we}, 32'h1);
        check("single_busy", {31'h0, busy}, 32'h1);
        repeat (WORD_CYC) @(negedge user_clk);
        check("single_busy_fall", {31'h0, busy}, 32'h0);
        check("single_we_fall", {31'h0, coef_we}, 32'h0);
        check("single_count", {16'h0, status[15:0]}, 32'd1);

        // fill from 1020: four consecutive writes, no wrap to 0
        for (int i = 0; i < 4; i++) expect_write(10'(1020 + i), 18'd7);
        commit(10'd1020, 18'd7, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            repeat ((i == 0) ? 1 : WORD_CYC) @(negedge user_clk);
            check("fill_top_we", {31'h0, coef_we}, 32'h1);
            check("fill_top_addr", {22'h0, coef_addr}, 32'(1020 + i));
        end
        wait_idle(20);
        check("fill_top_count", {16'h0, status[15:0]}, 32'd5);

        // full fill with a dropped commit in flight, then clear
        for (int i = 0; i < 1024; i++) expect_write(10'(i), 18'h25555);
        commit(10'd0, 18'h25555, 1'b1, 1'b0);
        repeat (10) @(negedge user_clk);
        commit(10'd9, 18'h00001, 1'b0, 1'b0);
        wait_idle(5000);
        check("fill_all_count", {16'h0, status[15:0]}, 32'd1029);
        check("fill_drop", {31'h0, status[18]}, 32'h1);
        check("fill_verr", {31'h0, status[17]}, {31'h0, VERIFY});
        commit(10'd2, 18'h00002, 1'b0, 1'b1);
        repeat (3) @(negedge user_clk);
        check("clr_drop", {31'h0, status[18]}, 32'h0);
        check("clr_verr", {31'h0, status[17]}, 32'h0);
        check("clr_count", {16'h0, status[15:0]}, 32'd1029);
        check("clr_busy", {31'h0, busy}, 32'h0);

        // reset at the 100th write of a fill
        for (int i = 0; i < 100; i++) expect_write(10'(i), 18'h00042);
        commit(10'd0, 18'h00042, 1'b1, 1'b0);
        for (int i = 0; i < 100; i++)
            repeat ((i == 0) ? 1 : WORD_CYC) @(negedge user_clk);
        #2 user_rst = 1'b1;
        #1;
        check("abort_we", {31'h0, coef_we}, 32'h0);
        check("abort_status", status, 32'h0);
        check("abort_addr", {22'h0, coef_addr}, 32'h0);
        @(negedge user_clk);
        user_rst = 1'b0;

        // next commit after reset behaves normally
        expect_write(10'h3FF, 18'h3FFFF);
        commit(10'h3FF, 18'h3FFFF, 1'b0, 1'b0);
        @(negedge user_clk);
        check("post_rst_we", {31'h0, coef_we}, 32'h1);
        wait_idle(20);
        check("post_rst_status", status, 32'h1);

        repeat (5) @(negedge user_clk);
        check("queue_drained", exp_q.size(), 0);
        check("total_writes", wr_seen, 1130);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
